// File: rtl/ship_rocket_if.sv
// Rocket bus between the ship/controller side, the rocket generator and the alien array.
// Carries the game inputs to the rocket block and the rocket position/score back out.
interface ship_rocket_if #(
    parameter int N_ALIENS = 8,
    parameter int SCORE_W  = 8
);
    logic                playing;
    logic                fire;
    logic [9:0]          shipX;
    logic [8:0]          shipY;
    logic [N_ALIENS-1:0] alienhits;

    logic                shiprocket;
    logic [9:0]          shiprocketX;
    logic [8:0]          shiprocketY;
    logic                hitpulse;
    logic [SCORE_W-1:0]  score;

    modport master (
        input  playing, fire, shipX, shipY, alienhits,
        output shiprocket, shiprocketX, shiprocketY, hitpulse, score
    );

    modport slave (
        output playing, fire, shipX, shipY, alienhits,
        input  shiprocket, shiprocketX, shiprocketY, hitpulse, score
    );
endinterface

// File: rtl/ship_rocket.sv
// Player rocket: launches on a fire edge, climbs SPEED px/clock, retires on a new alien hit or at TOP.
// Launch shows one clock after the registered fire edge, retire one clock after a hit; no backpressure.
module ship_rocket #(
    parameter int N_ALIENS = 8,
    parameter int SPEED    = 4,
    parameter int SHIP_H   = 16,
    parameter int TOP      = 8,
    parameter int COOLDOWN = 15,
    parameter int SCORE_W  = 8
) (
    input  logic          clk,
    input  logic          reset,
    ship_rocket_if.master bus
);
    localparam int               CNT_W      = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(COOLDOWN - 1);
    localparam logic [8:0]       LAUNCH_MIN = 9'(SHIP_H + TOP);
    localparam logic [8:0]       LAUNCH_OFS = 9'(SHIP_H);
    localparam logic [8:0]       TOP_LIMIT  = 9'(TOP + SPEED);
    localparam logic [8:0]       STEP       = 9'(SPEED);
    localparam logic [9:0]       PARK_X     = 10'd1023;
    localparam logic [8:0]       PARK_Y     = 9'd511;
    localparam int               SUM_W      = SCORE_W + $clog2(N_ALIENS + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        FLYING,
        COOLD
    } state_t;

    state_t              state;
    logic                fire_q;
    logic                fire_rise;
    logic                playing_q;
    logic [N_ALIENS-1:0] hits_q;
    logic [N_ALIENS-1:0] new_hits;
    logic [CNT_W-1:0]    cool_cnt;
    logic [SUM_W-1:0]    hit_count;
    logic [SUM_W-1:0]    score_sum;
    logic [SCORE_W-1:0]  score_next;

    assign new_hits = bus.alienhits & ~hits_q;

    always_comb begin
        hit_count = '0;
        for (int i = 0; i < N_ALIENS; i++) begin
            hit_count = hit_count + SUM_W'(new_hits[i]);
        end
    end

    assign score_sum  = SUM_W'(bus.score) + hit_count;
    assign score_next = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];

    // The fire edge is registered, so a launch lands one clock after the edge is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            fire_q          <= 1'b0;
            fire_rise       <= 1'b0;
            playing_q       <= 1'b0;
            hits_q          <= '0;
            cool_cnt        <= '0;
            bus.shiprocket  <= 1'b0;
            bus.shiprocketX <= PARK_X;
            bus.shiprocketY <= PARK_Y;
            bus.hitpulse    <= 1'b0;
            bus.score       <= '0;
        end else begin
            fire_q       <= bus.fire;
            fire_rise    <= bus.fire & ~fire_q;
            playing_q    <= bus.playing;
            bus.hitpulse <= 1'b0;

            if (!bus.playing) begin
                state           <= IDLE;
                hits_q          <= '0;
                cool_cnt        <= '0;
                bus.shiprocket  <= 1'b0;
                bus.shiprocketX <= PARK_X;
                bus.shiprocketY <= PARK_Y;
            end else begin
                hits_q <= bus.alienhits;
                if (!playing_q) begin
                    bus.score <= '0;
                end

                case (state)
                    IDLE: begin
                        if (fire_rise && bus.shipY >= LAUNCH_MIN) begin
                            state           <= FLYING;
                            bus.shiprocket  <= 1'b1;
                            bus.shiprocketX <= bus.shipX;
                            bus.shiprocketY <= bus.shipY - LAUNCH_OFS;
                        end
                    end

                    FLYING: begin
                        if (|new_hits) begin
                            state           <= COOLD;
                            cool_cnt        <= COOL_LOAD;
                            bus.shiprocket  <= 1'b0;
                            bus.shiprocketX <= PARK_X;
                            bus.shiprocketY <= PARK_Y;
                            bus.hitpulse    <= 1'b1;
                            bus.score       <= score_next;
                        end else if (bus.shiprocketY < TOP_LIMIT) begin
                            state           <= COOLD;
                            cool_cnt        <= COOL_LOAD;
                            bus.shiprocket  <= 1'b0;
                            bus.shiprocketX <= PARK_X;
                            bus.shiprocketY <= PARK_Y;
                        end else begin
                            bus.shiprocketY <= bus.shiprocketY - STEP;
                        end
                    end

                    COOLD: begin
                        if (cool_cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            cool_cnt <= cool_cnt - CNT_W'(1);
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ship_rocket.sv
// Bench for ship_rocket: directed scenarios then random play, all checked against a cycle model.
module tb_ship_rocket;
    localparam int NA       = 8;
    localparam int SPEED    = 4;
    localparam int SHIP_H   = 16;
    localparam int TOP      = 8;
    localparam int COOLDOWN = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          playing;
    logic          fire;
    logic [9:0]    ship_x;
    logic [8:0]    ship_y;
    logic [NA-1:0] hits;

    ship_rocket_if #(.N_ALIENS(NA), .SCORE_W(8)) bus ();
    ship_rocket_if #(.N_ALIENS(NA), .SCORE_W(2)) bus_s ();

    assign bus.playing     = playing;
    assign bus.fire        = fire;
    assign bus.shipX       = ship_x;
    assign bus.shipY       = ship_y;
    assign bus.alienhits   = hits;
    assign bus_s.playing   = playing;
    assign bus_s.fire      = fire;
    assign bus_s.shipX     = ship_x;
    assign bus_s.shipY     = ship_y;
    assign bus_s.alienhits = hits;

    ship_rocket #(.N_ALIENS(NA), .SPEED(SPEED), .SHIP_H(SHIP_H), .TOP(TOP),
                  .COOLDOWN(COOLDOWN), .SCORE_W(8)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    ship_rocket #(.N_ALIENS(NA), .SPEED(SPEED), .SHIP_H(SHIP_H), .TOP(TOP),
                  .COOLDOWN(COOLDOWN), .SCORE_W(2)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: rocket either flying at (m_x, m_y) or parked; launches allowed from edge idle_from on.
    int          cyc;
    int          idle_from;
    bit          m_fly;
    int          m_x;
    int          m_y;
    bit          m_pulse;
    int          m_score8;
    int          m_score2;
    bit          m_fire_q;
    bit          m_fire_rise;
    bit          m_play_q;
    bit [NA-1:0] m_hits_q;

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        idle_from   = cyc;
        m_fly       = 1'b0;
        m_x         = 0;
        m_y         = 0;
        m_pulse     = 1'b0;
        m_score8    = 0;
        m_score2    = 0;
        m_fire_q    = 1'b0;
        m_fire_rise = 1'b0;
        m_play_q    = 1'b0;
        m_hits_q    = '0;
    endtask

    task automatic model_step();
        bit [NA-1:0] nh;
        int          pc;
        nh      = hits & ~m_hits_q;
        pc      = $countones(nh);
        m_pulse = 1'b0;
        if (!playing) begin
            m_fly     = 1'b0;
            idle_from = cyc + 1;
            m_hits_q  = '0;
        end else begin
            if (!m_play_q) begin
                m_score8 = 0;
                m_score2 = 0;
            end
            if (m_fly) begin
                if (pc != 0) begin
                    m_fly     = 1'b0;
                    idle_from = cyc + COOLDOWN + 1;
                    m_pulse   = 1'b1;
                    m_score8  = (m_score8 + pc > 255) ? 255 : m_score8 + pc;
                    m_score2  = (m_score2 + pc > 3) ? 3 : m_score2 + pc;
                end else if (m_y < TOP + SPEED) begin
                    m_fly     = 1'b0;
                    idle_from = cyc + COOLDOWN + 1;
                end else begin
                    m_y = m_y - SPEED;
                end
            end else if (cyc >= idle_from && m_fire_rise && int'(ship_y) >= SHIP_H + TOP) begin
                m_fly = 1'b1;
                m_x   = int'(ship_x);
                m_y   = int'(ship_y) - SHIP_H;
            end
            m_hits_q = hits;
        end
        m_fire_rise = fire & ~m_fire_q;
        m_fire_q    = fire;
        m_play_q    = playing;
        cyc++;
    endtask

    task automatic compare_all();
        chk("shiprocket", int'(bus.shiprocket), int'(m_fly));
        chk("shiprocketX", int'(bus.shiprocketX), m_fly ? m_x : 1023);
        chk("shiprocketY", int'(bus.shiprocketY), m_fly ? m_y : 511);
        chk("hitpulse", int'(bus.hitpulse), int'(m_pulse));
        chk("score", int'(bus.score), m_score8);
        chk("score_small", int'(bus_s.score), m_score2);
        chk("shiprocketY_small", int'(bus_s.shiprocketY), m_fly ? m_y : 511);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic launch();
        fire = 1'b1;
        cycle();
        fire = 1'b0;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_y;
        int seen;
        int idx;

        cyc     = 0;
        reset   = 1'b1;
        playing = 1'b0;
        fire    = 1'b0;
        hits    = '0;
        ship_x  = 10'd320;
        ship_y  = 9'd440;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_shiprocket", int'(bus.shiprocket), 0);
        chk("reset_x", int'(bus.shiprocketX), 1023);
        chk("reset_y", int'(bus.shiprocketY), 511);
        chk("reset_score", int'(bus.score), 0);
        chk("reset_hitpulse", int'(bus.hitpulse), 0);
        reset = 1'b0;

        // Launch and climb.
        playing = 1'b1;
        cycle();
        fire = 1'b1;
        cycle();
        chk("launch_not_yet", int'(bus.shiprocket), 0);
        fire = 1'b0;
        cycle();
        chk("launch_vld", int'(bus.shiprocket), 1);
        chk("launch_x", int'(bus.shiprocketX), 320);
        chk("launch_y", int'(bus.shiprocketY), 424);
        cycle();
        chk("climb_y", int'(bus.shiprocketY), 420);

        // Uncontested climb to the top.
        last_y = int'(bus.shiprocketY);
        seen   = 0;
        for (int i = 0; i < 200 && bus.shiprocket; i++) begin
            last_y = int'(bus.shiprocketY);
            cycle();
            seen += int'(bus.hitpulse);
        end
        chk("top_parked", int'(bus.shiprocket), 0);
        chk("top_last_y", last_y, 8);
        chk("top_park_y", int'(bus.shiprocketY), 511);
        chk("top_score", int'(bus.score), 0);
        chk("top_no_pulse", seen, 0);

        // Fire during cooldown is discarded.
        seen = 0;
        for (int i = 1; i <= COOLDOWN; i++) begin
            fire = (i == 3);
            cycle();
            seen += int'(bus.shiprocket);
        end
        chk("cool_block", seen, 0);
        launch();
        chk("relaunch", int'(bus.shiprocket), 1);

        // Single hit, then sticky flag held high.
        cycle();
        hits[3] = 1'b1;
        cycle();
        chk("hit_parked", int'(bus.shiprocket), 0);
        chk("hit_pulse", int'(bus.hitpulse), 1);
        chk("hit_score", int'(bus.score), 1);
        cycle();
        chk("hit_pulse_clear", int'(bus.hitpulse), 0);
        repeat (COOLDOWN - 1) cycle();
        launch();
        repeat (3) cycle();
        chk("sticky_in_flight", int'(bus.shiprocket), 1);
        chk("sticky_score", int'(bus.score), 1);

        // Double hit and saturation of the narrow score.
        hits[0] = 1'b1;
        hits[5] = 1'b1;
        cycle();
        chk("dbl_score", int'(bus.score), 3);
        chk("dbl_small", int'(bus_s.score), 3);
        repeat (COOLDOWN) cycle();
        launch();
        cycle();
        hits[7] = 1'b1;
        cycle();
        chk("sat_score", int'(bus.score), 4);
        chk("sat_small", int'(bus_s.score), 3);

        // Fire held across cooldown expiry.
        repeat (2) cycle();
        fire = 1'b1;
        seen = 0;
        repeat (25) begin
            cycle();
            seen += int'(bus.shiprocket);
        end
        chk("held_no_launch", seen, 0);
        fire = 1'b0;
        cycle();
        launch();
        chk("held_relaunch", int'(bus.shiprocket), 1);

        // Low ship cannot launch.
        repeat (3) cycle();
        playing = 1'b0;
        cycle();
        chk("go_parked", int'(bus.shiprocket), 0);
        chk("go_score_held", int'(bus.score), 4);
        repeat (3) cycle();
        playing = 1'b1;
        hits[4] = 1'b1;
        cycle();
        chk("restart_score", int'(bus.score), 0);
        cycle();
        chk("idle_hit_unscored", int'(bus.score), 0);
        ship_y = 9'd20;
        launch();
        cycle();
        chk("low_ship_ignored", int'(bus.shiprocket), 0);
        ship_y = 9'd440;

        // Asynchronous reset mid-flight.
        launch();
        cycle();
        #2 reset = 1'b1;
        #1;
        chk("async_park", int'(bus.shiprocket), 0);
        chk("async_x", int'(bus.shiprocketX), 1023);
        #1 reset = 1'b0;
        model_reset();
        hits = '0;
        cycle();

        // Random play.
        for (int n = 0; n < 4000; n++) begin
            if (playing && $urandom_range(0, 299) == 0) playing = 1'b0;
            else if (!playing && $urandom_range(0, 9) == 0) playing = 1'b1;
            if ($urandom_range(0, 3) == 0) fire = ~fire;
            if ($urandom_range(0, 39) == 0) begin
                idx       = int'($urandom_range(0, NA - 1));
                hits[idx] = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) hits = '0;
            if ($urandom_range(0, 19) == 0) begin
                ship_y = 9'($urandom_range(0, 511));
                ship_x = 10'($urandom_range(0, 1023));
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ship_rocket.md
# ship_rocket

Generates the player's rocket. It consumes the alien row's hit flags and drives the `shiprocket` / `shiprocketX` / `shiprocketY` bus that every `alien` instance compares against.
- On a fire press it launches one rocket from the ship's nose and moves it upward each clock.
- It retires the rocket when an alien reports a new hit or when the rocket reaches the top of the screen.
- It keeps the score.
- It sits between the ship/controller logic and the alien array in the game top level.

## Interface
Parameters:
- N_ALIENS, 8, number of alien hit flags on `alienhits`
- SPEED, 4, pixels the rocket rises per clock
- SHIP_H, 16, launch offset above `shipY`
- TOP, 8, smallest Y the rocket may occupy
- COOLDOWN, 15, idle clocks after a retire before the next launch is allowed
- SCORE_W, 8, score counter width

Ports:
- clk  in  1  game clock; the only clock
- reset  in  1  asynchronous, active-high
- playing  in  1  game-active level
- fire  in  1  fire button, already synchronous to clk
- shipX  in  10  ship centre X
- shipY  in  9  ship top Y
- alienhits  in  N_ALIENS  per-alien `alienhit` levels; each is sticky high once that alien is hit
- shiprocket  out  1  rocket in flight
- shiprocketX  out  10  rocket X
- shiprocketY  out  9  rocket Y
- hitpulse  out  1  one-clock pulse on each scoring event
- score  out  SCORE_W  aliens destroyed, saturating

## Operation
- States: IDLE, FLYING, COOLD.
- Edge detection:
  - `fire_q` and `hits_q` are registered copies of `fire` and `alienhits`.
  - Fire edge = fire & ~fire_q.
  - New hits = alienhits & ~hits_q.
- Parked position is X=1023, Y=511.
  - The rocket is parked whenever the state is not FLYING.
  - 1023 keeps `shiprocketX+2 < alienX+border` false for any on-screen alien, so a parked rocket never causes a hit.
- IDLE → FLYING on a fire edge when playing=1 and shipY ≥ SHIP_H+TOP.
  - Load X=shipX and Y=shipY−SHIP_H.
  - A fire edge with shipY < SHIP_H+TOP is ignored.
- FLYING, evaluated in priority order each clock:
  1. If new hits ≠ 0: go to COOLD and park. Score += popcount(new hits), saturating at 2^SCORE_W−1. hitpulse=1.
  2. Else if shiprocketY < TOP+SPEED: go to COOLD and park (miss, no score).
  3. Else Y −= SPEED. X is held constant.
- COOLD:
  - A counter loads COOLDOWN−1 on entry and decrements each clock.
  - At 0 → IDLE.
  - Fire edges during COOLD are discarded and not queued; a new press is required.
- New hits arriving while in IDLE or COOLD are never scored. They still update hits_q.
- playing=0, synchronous, overrides everything:
  - State → IDLE and the rocket parks.
  - hits_q ← 0, matching the aliens clearing their flags.
  - Cooldown counter ← 0.
  - Score is held, so the end-of-game score stays visible.
- Score clears on reset and on the clock where playing rises (playing=1 and a registered playing_q=0).

## Timing
- Reset values:
  - state IDLE, shiprocket 0, shiprocketX 1023, shiprocketY 511.
  - hitpulse 0, score 0.
  - fire_q, hits_q and playing_q all 0.
- All outputs are registered.
- Launch latency: with fire rising before edge N, outputs show shiprocket=1 and the launch coordinates after edge N+1.
- Retire latency is one clock from the alien's `alienhit` rise. shiprocket=0 and hitpulse=1 appear on the same edge; hitpulse clears on the next edge.
- Minimum launch spacing after a retire is COOLDOWN+1 clocks, plus the fire edge-detect clock.
- Y arithmetic is 9-bit. The top check guarantees the decrement never wraps.
- Reset mid-flight parks the rocket immediately, asynchronously.

## Test plan
- **Launch.** reset, playing=1, shipX=320, shipY=440, pulse fire for 1 clock → shiprocket=1 with X=320, Y=424 one clock later. Y reads 420, then 416, and so on.
- **Top miss.** Let the rocket rise uncontested → last in-flight Y is 8 (values 424…12, 8), then parked at 1023/511. Score stays 0, no hitpulse. fire is ignored for 15 clocks, then a new edge launches.
- **Hit.** In flight, raise alienhits[3] and hold it high → next clock shiprocket=0, hitpulse=1 for one clock, score=1. Holding bit 3 high produces no further score.
- **Double hit and saturation.** Bits 0 and 5 rise on the same clock → score +2. With SCORE_W=2 starting at score=3, a hit leaves score=3.
- **Held fire.** Hold fire high across cooldown expiry → no launch. Release and press again → launch.
- **Game over mid-flight.** playing=0 mid-flight → parked next clock, score held. playing back to 1 → score=0, and an old sticky alienhit rise is not scored while IDLE.
